// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator weight path.
// Sequencer state, table depth and row-phase gray code helpers.
package cnn_layer_accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam int C_SEQ_LEN = 5;

  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;

  function automatic logic [1:0] next_gray2(
    input logic [1:0] g
  );
    logic [1:0] n;
    n = GRAY_0;
    unique case (g)
      GRAY_0: n = GRAY_1;
      GRAY_1: n = GRAY_2;
      GRAY_2: n = GRAY_3;
      GRAY_3: n = GRAY_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_weight_sequencer_if.sv
// Control and table-address bundle between the layer controller,
// the weight sequencer and the weight sequence table.
interface cnn_layer_accel_weight_sequencer_if #(
  parameter int C_ROW_W = 8,
  parameter int C_COL_W = 10
);

  logic               start;
  logic [C_ROW_W-1:0] num_rows;
  logic [C_COL_W-1:0] num_cols;
  logic               stall;
  logic [1:0]         gray_code;
  logic               sequence_selector;
  logic [2:0]         seq_data_addr;
  logic               seq_valid;
  logic               busy;
  logic               done;

  modport master (
    input  start,
    input  num_rows,
    input  num_cols,
    input  stall,
    output gray_code,
    output sequence_selector,
    output seq_data_addr,
    output seq_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output num_rows,
    output num_cols,
    output stall,
    input  gray_code,
    input  sequence_selector,
    input  seq_data_addr,
    input  seq_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/cnn_layer_accel_gray_counter2.sv
// Two-bit gray code counter, 00->01->11->10->00.
// Synchronous clear has priority over enable.
module cnn_layer_accel_gray_counter2
  import cnn_layer_accel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= GRAY_0;
    end else if (en) begin
      q <= next_gray2(q);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Walks rows x kernel columns x table depth, emitting one weight
// sequence table address per unstalled cycle.
module cnn_layer_accel_weight_sequencer
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_ROW_W = 8,
  parameter int C_COL_W = 10
) (
  input logic clk,
  input logic rst,
  cnn_layer_accel_weight_sequencer_if.master bus
);

  localparam logic [2:0] ADDR_LAST = 3'(C_SEQ_LEN - 1);

  seq_state_t         state;
  logic [C_ROW_W-1:0] rows_q;
  logic [C_COL_W-1:0] cols_q;
  logic [C_ROW_W-1:0] row;
  logic [C_COL_W-1:0] col;
  logic [2:0]         addr;
  logic               sel;
  logic               valid;
  logic               busy;
  logic               done;
  logic [1:0]         gray;

  logic addr_last;
  logic col_last;
  logic row_last;
  logic run_go;
  logic gray_clr;
  logic gray_en;

  assign addr_last = addr == ADDR_LAST;
  assign col_last  = col == cols_q - C_COL_W'(1);
  assign row_last  = row == rows_q - C_ROW_W'(1);
  assign run_go    = state == RUN && !bus.stall;

  // Gray code steps only on a row change that is not the final one.
  assign gray_clr = state == IDLE && bus.start;
  assign gray_en  = run_go && addr_last && col_last && !row_last;

  cnn_layer_accel_gray_counter2 u_gray (
    .clk (clk),
    .rst (rst),
    .clr (gray_clr),
    .en  (gray_en),
    .q   (gray)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      row    <= '0;
      col    <= '0;
      addr   <= '0;
      sel    <= 1'b1;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rows_q <= bus.num_rows;
            cols_q <= bus.num_cols;
            row    <= '0;
            col    <= '0;
            addr   <= '0;
            sel    <= 1'b1;
            busy   <= 1'b1;
            if (bus.num_rows == '0 || bus.num_cols == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stall) begin
            valid <= 1'b0;
          end else if (!addr_last) begin
            addr  <= addr + 3'd1;
            valid <= 1'b1;
          end else if (!col_last) begin
            addr  <= '0;
            sel   <= ~sel;
            col   <= col + C_COL_W'(1);
            valid <= 1'b1;
          end else if (!row_last) begin
            addr  <= '0;
            sel   <= 1'b1;
            col   <= '0;
            row   <= row + C_ROW_W'(1);
            valid <= 1'b1;
          end else begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // An empty pass enters here with done low and pulses one cycle later.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gray_code         = gray;
  assign bus.sequence_selector = sel;
  assign bus.seq_data_addr     = addr;
  assign bus.seq_valid         = valid;
  assign bus.busy              = busy;
  assign bus.done              = done;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Bench for the weight sequencer: vector table of passes with a
// scoreboard of expected table addresses, plus reset corner cases.
module tb_cnn_layer_accel_weight_sequencer;

  typedef struct packed {
    logic [1:0] gray;
    logic       sel;
    logic [2:0] addr;
  } exp_t;

  typedef struct {
    int rows;
    int cols;
    int s_at;
    int s_len;
    int rs_at;
    int exp_valid;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  vec_t vecs[9];

  cnn_layer_accel_weight_sequencer_if #(
    .C_ROW_W(8),
    .C_COL_W(10)
  ) bus ();

  cnn_layer_accel_weight_sequencer #(
    .C_ROW_W(8),
    .C_COL_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (bus.seq_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_pop: seq_valid with no expected entry, addr %0d",
                 bus.seq_data_addr);
      end else begin
        mon_e = q.pop_front();
        check("seq", {bus.gray_code, bus.sequence_selector,
                      bus.seq_data_addr}, mon_e);
      end
    end
  end

  task automatic push_pass(input int rows, input int cols,
                           output exp_t el[$]);
    exp_t e;
    el.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int a = 0; a < 5; a++) begin
          e.gray = gtab[r % 4];
          e.sel  = (c % 2 == 0);
          e.addr = 3'(a);
          el.push_back(e);
          q.push_back(e);
        end
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {bus.gray_code, bus.sequence_selector, bus.seq_data_addr,
                 bus.seq_valid, bus.busy, bus.done}, 9'b00_1_000_000);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t el[$];
    int   vcnt;
    bit   seen;
    push_pass(v.rows, v.cols, el);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.num_rows = 8'(v.rows);
    bus.num_cols = 10'(v.cols);
    @(posedge clk);
    vcnt = 0;
    seen = 1'b0;
    for (int j = 0; j < 300 && !seen; j++) begin
      @(negedge clk);
      bus.start = (j == v.rs_at);
      if (j == v.rs_at) begin
        bus.num_rows = 8'd3;
        bus.num_cols = 10'd3;
      end
      bus.stall = (j + 1 >= v.s_at) && (j + 1 < v.s_at + v.s_len);
      if (j == 0) check("busy_t1", bus.busy, 1);
      if (v.s_len > 0 && j >= v.s_at && j < v.s_at + v.s_len) begin
        check("stall_valid", bus.seq_valid, 0);
        check("stall_addr", bus.seq_data_addr, el[v.s_at - 1].addr);
      end
      if (bus.seq_valid) vcnt++;
      if (bus.done) begin
        seen = 1'b1;
        check("done_cycle", j + 1, v.exp_done);
        check("busy_at_done", bus.busy, 0);
      end
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("done_seen", seen, 1);
    check("valid_count", vcnt, v.exp_valid);
    check("sb_drained", q.size(), 0);
    @(negedge clk);
    check("done_pulse_end", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    exp_t el[$];
    int   dn;
    vecs[0] = '{1, 1, 0, 0, -1, 5, 6};
    vecs[1] = '{1, 2, 0, 0, -1, 10, 11};
    vecs[2] = '{5, 1, 0, 0, -1, 25, 26};
    vecs[3] = '{1, 1, 3, 2, -1, 5, 8};
    vecs[4] = '{0, 3, 0, 0, -1, 0, 2};
    vecs[5] = '{2, 0, 0, 0, -1, 0, 2};
    vecs[6] = '{3, 3, 7, 3, -1, 45, 49};
    vecs[7] = '{2, 2, 0, 0, -1, 20, 21};
    vecs[8] = '{1, 2, 0, 0, 3, 10, 11};

    bus.start    = 1'b1;
    bus.num_rows = 8'd2;
    bus.num_cols = 10'd2;
    bus.stall    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_state");
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("idle_after_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    push_pass(2, 2, el);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.num_rows = 8'd2;
    bus.num_cols = 10'd2;
    @(posedge clk);
    repeat (6) @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("abort_reset");
    rst = 1'b0;
    q.delete();
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.seq_valid) dn++;
    end
    check("no_done_after_abort", dn, 0);
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
